regfile_write_arbiter: RTL
==========================

# regfile_write_arbiter

Round-robin arbiter that shares the register file's single write port among `NREQ` requesters (e.g. ALU writeback, load unit, debug port). Each cycle it grants at most one valid request, registers the winning address/data, and drives the register file's write enable, write address, write data and one-hot per-register write strobes one cycle later. It sits directly in front of the 32x32 register file and replaces the file's direct write-port connection.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  request i pending; held high until granted
- `req_addr`  in  5*NREQ  write address, requester i at bits [5i+4:5i]
- `req_data`  in  32*NREQ  write data, requester i at bits [32i+31:32i]
- `req_gnt`  out  NREQ  one-hot grant, combinational, same cycle as acceptance
- `wr_en`  out  1  register file write enable (registered)
- `wr_addr`  out  5  register file write address (registered)
- `wr_data`  out  32  register file write data (registered)
- `wr_strobe`  out  32  one-hot per-register write strobe, `wr_en << wr_addr`, forced 0 for address 0
- `req_lock`  in  NREQ  hold-grant request; present only with `REGFILE_ARB_LOCK_EN`

## Operation
- Round-robin pointer `ptr` (log2 NREQ bits) holds the highest-priority index; search order ptr, ptr+1, ..., wrapping modulo NREQ.
- `req_gnt[i]` = 1 for the first i in search order with `req_valid[i]`; all zero if no valid request.
- Acceptance: a request is accepted on a rising edge where `req_valid[i] & req_gnt[i]`. Requester drops or changes its request in the following cycle.
- On acceptance: `ptr <= (i+1) mod NREQ`; `wr_en <= 1`, `wr_addr <= req_addr[i]`, `wr_data <= req_data[i]`.
- No acceptance: `wr_en <= 0`; `wr_addr`/`wr_data` hold previous values; `ptr` unchanged.
- Address 0 writes are accepted and granted normally, but `wr_en` is driven 0 and `wr_strobe` is all zeros (register zero is hardwired).
- `wr_strobe` is derived combinationally from the registered `wr_en`/`wr_addr`.
- Requests are never dropped: a continuously valid requester is granted within NREQ cycles.

## Timing
- Grant: 0 cycles (combinational from `req_valid`, `ptr`).
- Write issue: 1 cycle after acceptance edge (`wr_*` valid in the cycle after `req_gnt`).
- Throughput: one write per cycle when any request is valid.
- Reset (`rst_n` low, asynchronous): `ptr`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `wr_strobe`=0; lock state cleared. `req_gnt` follows its combinational equation with ptr=0. A write registered in the cycle reset asserts is discarded.
- Reset release: first arbitration on the first rising edge with `rst_n` high.
- Simultaneous requests: exactly one grant; others stay pending with `req_valid` high.

## Configuration
- `REGFILE_ARB_LOCK_EN` defined: `req_lock` port exists. If the accepted requester has `req_lock[i]`=1, arbiter enters LOCKED(i): only requester i can be granted; others see `req_gnt`=0. LOCKED(i) exits to round-robin (IDLE) when i is accepted with `req_lock[i]`=0 or when `req_valid[i]` is low at a clock edge. `ptr` advances to i+1 on lock exit. Reset forces IDLE.
- Not defined: no `req_lock` port, no lock state; pure round-robin as above.

## Test plan
- Reset: hold `rst_n`=0 with all `req_valid`=1 -> `wr_en`=0, `wr_strobe`=0; after release first grant is `req_gnt`=4'b0001.
- Single requester: `req_valid`=4'b0100, addr 5, data 0xDEADBEEF -> `req_gnt`=4'b0100 same cycle; next cycle `wr_en`=1, `wr_addr`=5, `wr_data`=0xDEADBEEF, `wr_strobe`=32'h00000020.
- Fairness: all four valid continuously for 8 cycles -> grant sequence 0,1,2,3,0,1,2,3; `wr_en`=1 every cycle after the first.
- Register zero: requester 1 writes addr 0 -> `req_gnt`=4'b0010, next cycle `wr_en`=0, `wr_strobe`=0, `ptr` advances to 2.
- Mid-operation reset: assert `rst_n`=0 asynchronously one cycle after acceptance of addr 7 -> `wr_en` drops immediately to 0, no strobe for register 7.
- Lock (macro on): requester 2 holds `req_lock`=1 for 3 accepted writes while requesters 0,3 valid -> grants 2,2,2, then with lock low 2 once more, then 3,0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Round-robin arbiter for the register file's single write
//               port. Grants one valid request per cycle (combinational
//               grant), registers the winning address/data and drives the
//               write enable, address, data and one-hot write strobes one
//               cycle later. Register 0 writes are accepted but never
//               enabled.
//               Optional feature macro: REGFILE_ARB_LOCK_EN adds the
//               req_lock_i port and a LOCKED state that holds the grant on
//               one requester.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [5*NREQ-1:0]    req_addr_i,
  input  logic [32*NREQ-1:0]   req_data_i,
`ifdef REGFILE_ARB_LOCK_EN
  input  logic [NREQ-1:0]      req_lock_i,
`endif
  output logic [NREQ-1:0]      req_gnt_o,
  output logic                 wr_en_o,
  output logic [4:0]           wr_addr_o,
  output logic [31:0]          wr_data_o,
  output logic [31:0]          wr_strobe_o
);

  localparam int            PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] C_LAST = PW'(NREQ - 1);
  localparam logic [NREQ-1:0] C_ONE = NREQ'(1);

  logic [PW-1:0]  ptr_q, ptr_d;
  logic           wr_en_q;
  logic [4:0]     wr_addr_q;
  logic [31:0]    wr_data_q;

  logic [NREQ-1:0] rr_gnt;
  logic [PW-1:0]   rr_idx;
  logic            rr_found;
  logic [PW-1:0]   win_idx;
  logic            accept;
  logic [4:0]      sel_addr;
  logic [31:0]     sel_data;

  // Round-robin search starting at ptr_q, wrapping modulo NREQ
  always_comb begin
    rr_gnt   = '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NREQ;
      if (!rr_found && req_valid_i[idx]) begin
        rr_found    = 1'b1;
        rr_idx      = PW'(idx);
        rr_gnt[idx] = 1'b1;
      end
    end
  end

`ifdef REGFILE_ARB_LOCK_EN
  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] lock_idx_q, lock_idx_d;

  // Lock state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // Grant selection and lock next-state: while locked only the owner competes
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    req_gnt_o  = rr_gnt;
    win_idx    = rr_idx;
    accept     = rr_found;
    if (state_q == S_LOCKED) begin
      win_idx   = lock_idx_q;
      accept    = req_valid_i[lock_idx_q];
      req_gnt_o = accept ? (C_ONE << lock_idx_q) : '0;
      // Owner withdrew, or was accepted with the lock released
      if (!accept || !req_lock_i[lock_idx_q]) begin
        state_d = S_IDLE;
      end
    end else if (accept && req_lock_i[win_idx]) begin
      state_d    = S_LOCKED;
      lock_idx_d = win_idx;
    end
  end
`else
  // Grant selection is pure round-robin
  always_comb begin
    req_gnt_o = rr_gnt;
    win_idx   = rr_idx;
    accept    = rr_found;
  end
`endif

  // Pointer update and winner payload mux
  always_comb begin
    ptr_d    = ptr_q;
    sel_addr = req_addr_i[5*win_idx +: 5];
    sel_data = req_data_i[32*win_idx +: 32];
    if (accept) begin
      ptr_d = (win_idx == C_LAST) ? '0 : win_idx + 1'b1;
    end
`ifdef REGFILE_ARB_LOCK_EN
    // Lock exit because the owner dropped its request still moves past it
    if (state_q == S_LOCKED && !accept) begin
      ptr_d = (lock_idx_q == C_LAST) ? '0 : lock_idx_q + 1'b1;
    end
`endif
  end

  // Write-port registers; register 0 is hardwired so its writes never enable
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      wr_en_q <= accept && (sel_addr != 5'd0);
      if (accept) begin
        wr_addr_q <= sel_addr;
        wr_data_q <= sel_data;
      end
    end
  end

  // One-hot strobe from the registered write, never for register 0
  always_comb begin
    wr_strobe_o = '0;
    if (wr_en_q && (wr_addr_q != 5'd0)) begin
      wr_strobe_o[wr_addr_q] = 1'b1;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;

endmodule
`default_nettype wire
